register_hazard_scoreboard: RTL and testbench
=============================================

// Module: register_hazard_scoreboard
// PURPOSE
//  Read-side companion of the destination-register write pipeline. Tracks per-register
//  count of in-flight writes between issue (decode) and writeback. Blocks issue of any
//  instruction whose source register, or saturated destination, is still pending.
//  Sits beside decode; its writeback input is the rd leaving the write pipeline.
// PARAMETERS
//  NREGS   32  architectural registers tracked (x0 never tracked)
//  ADDR_W  5   register address width, log2(NREGS)
//  CNT_W   2   per-register pending counter width
//  MAXPEND 3   max in-flight writes per register; equals write-pipeline depth
// PORTS
//  clk           in   1       processor main clock, all state on posedge
//  rst           in   1       synchronous, active-high reset
//  issue_valid   in   1       decode presents an instruction this cycle
//  issue_rd      in   ADDR_W  destination of presented instruction (0 = no write)
//  issue_rs1     in   ADDR_W  source 1 address
//  issue_rs2     in   ADDR_W  source 2 address
//  use_rs1       in   1       instruction reads rs1
//  use_rs2       in   1       instruction reads rs2
//  wb_valid      in   1       a write retires this cycle
//  wb_rd         in   ADDR_W  register written at writeback
//  stall         out  1       combinational; 1 = do not issue this cycle
//  issue_fire    out  1       combinational; issue_valid & ~stall
//  pending_mask  out  NREGS   registered; bit i = count[i] != 0; bit 0 always 0
//  err_underflow out  1       registered, sticky; writeback to register with count 0
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all counts 0, pending_mask 0, err_underflow 0; issue/wb ignored.
//  - Issue: on issue_fire with issue_rd!=0, count[issue_rd] += 1 at next posedge.
//  - Writeback: wb_valid with wb_rd!=0: count[wb_rd] -= 1 at next posedge.
//  - Same register issued and retired same cycle: net change 0; mask bit unchanged.
//  - Underflow: wb to register with count 0 -> count stays 0, err_underflow set (cleared only by rst).
//  - Writes to x0 from either side ignored; x0 never busy.
//  - busy(r) = (count[r]!=0) & ~(wb_valid & wb_rd==r & count[r]==1); regfile writes
//    before read in the same cycle, so the final retiring write does not stall.
//  - stall = issue_valid & ( (use_rs1 & busy(rs1)) | (use_rs2 & busy(rs2))
//            | (issue_rd!=0 & count[issue_rd]==MAXPEND & ~(wb_valid & wb_rd==issue_rd)) ).
//  - stall is 0 when issue_valid=0. Zero-cycle latency from inputs to stall.
//  - Counts saturate: never exceed MAXPEND (guaranteed by stall), never below 0.
//  - rst asserted mid-operation discards all pending state; first cycle after reset
//    sees an empty scoreboard.
// STRUCTURE
//  - Shared package: ADDR_W, NREGS, CNT_W, MAXPEND constants; REG_ZERO = 5'd0.
//  - Sub-module scoreboard_counter (one per register, generate loop 1..NREGS-1):
//    inc, dec, rst inputs; count, nonzero, at_max outputs; underflow pulse.
//  - Top level: rd/rs decoders, busy mux, stall logic, sticky error OR-reduce.
// TESTING
//  1 rst, then issue rd=5 (no sources) -> next cycle pending_mask=32'h20, stall=0.
//  2 pending x5, issue rs1=5 use_rs1=1 -> stall=1 until wb_rd=5; in wb cycle stall=0, fire=1.
//  3 issue rd=7 three times, 4th issue rd=7 -> stall=1; wb_rd=7 same cycle -> stall=0, count stays 3.
//  4 issue rd=0 / wb_rd=0 / rs1=0 use_rs1=1 -> mask stays 0, stall=0, no error.
//  5 wb_rd=9 with count 0 -> err_underflow=1 next cycle, stays 1; clears only after rst.
//  6 x3 pending count 2, assert rst one cycle -> mask=0; issue rs2=3 use_rs2=1 -> stall=0.

Source files
------------

// File: rtl/register_hazard_scoreboard_pkg.sv
// Shared constants for the register hazard scoreboard.
// Sizes the per-register pending-write counters.
package register_hazard_scoreboard_pkg;

    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 2;

    localparam logic [CNT_W-1:0]  MAXPEND  = 2'd3;
    localparam logic [CNT_W-1:0]  CNT_ZERO = 2'd0;
    localparam logic [CNT_W-1:0]  CNT_ONE  = 2'd1;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/register_hazard_scoreboard_counter.sv
// Pending-write counter for one architectural register.
// Saturates at MAXPEND and at zero; flags retire-at-zero.
module scoreboard_counter
    import register_hazard_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             at_max,
    output logic             underflow
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // next count: simultaneous issue and retire cancel out
    always_comb begin
        count_d = count_q;
        unique case ({inc, dec})
            2'b10: begin
                if (count_q != MAXPEND)
                    count_d = count_q + CNT_ONE;
            end
            2'b01: begin
                if (count_q != CNT_ZERO)
                    count_d = count_q - CNT_ONE;
            end
            default: count_d = count_q;
        endcase
    end

    // counter state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst)
            count_q <= CNT_ZERO;
        else
            count_q <= count_d;
    end

    assign count     = count_q;
    assign nonzero   = (count_q != CNT_ZERO);
    assign at_max    = (count_q == MAXPEND);
    assign underflow = dec & (count_q == CNT_ZERO);

endmodule

// File: rtl/register_hazard_scoreboard.sv
// Decode-side hazard scoreboard: counts in-flight writes
// per register and stalls issue on RAW or counter saturation.
module register_hazard_scoreboard
    import register_hazard_scoreboard_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] issue_rs1,
    input  logic [ADDR_W-1:0] issue_rs2,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    output logic              stall,
    output logic              issue_fire,
    output logic [NREGS-1:0]  pending_mask,
    output logic              err_underflow
);

    logic [CNT_W-1:0] cnt [NREGS];
    logic [NREGS-1:0] inc_vec;
    logic [NREGS-1:0] dec_vec;
    logic [NREGS-1:0] nz_vec;
    logic [NREGS-1:0] max_vec;
    logic [NREGS-1:0] uf_vec;
    logic [NREGS-1:0] busy_vec;

    logic rs1_hit;
    logic rs2_hit;
    logic rd_full;

    logic err_q;
    logic err_d;

    // x0 is never tracked
    assign cnt[0]     = CNT_ZERO;
    assign nz_vec[0]  = 1'b0;
    assign max_vec[0] = 1'b0;
    assign uf_vec[0]  = 1'b0;

    genvar g;
    generate
        for (g = 1; g < NREGS; g++) begin : g_cnt
            scoreboard_counter u_cnt (
                .clk       (clk),
                .rst       (rst),
                .inc       (inc_vec[g]),
                .dec       (dec_vec[g]),
                .count     (cnt[g]),
                .nonzero   (nz_vec[g]),
                .at_max    (max_vec[g]),
                .underflow (uf_vec[g])
            );
        end
    endgenerate

    // one-hot rd decoders for issue and writeback
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 1; i < NREGS; i++) begin
            inc_vec[i] = issue_fire
                       & (issue_rd == ADDR_W'(i));
            dec_vec[i] = wb_valid
                       & (wb_rd == ADDR_W'(i));
        end
    end

    // busy unless the last pending write retires now
    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < NREGS; i++) begin
            busy_vec[i] = nz_vec[i]
                        & ~(dec_vec[i]
                            & (cnt[i] == CNT_ONE));
        end
    end

    // stall on source hazard or saturated destination
    always_comb begin
        rs1_hit = use_rs1 & busy_vec[issue_rs1];
        rs2_hit = use_rs2 & busy_vec[issue_rs2];
        rd_full = (issue_rd != REG_ZERO)
                & max_vec[issue_rd]
                & ~dec_vec[issue_rd];
        stall   = issue_valid
                & (rs1_hit | rs2_hit | rd_full);
    end

    assign issue_fire   = issue_valid & ~stall;
    assign pending_mask = nz_vec;

    // sticky underflow flag, cleared only by reset
    always_comb begin
        err_d = err_q | (|uf_vec);
    end

    // error flag state
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign err_underflow = err_q;

endmodule

// File: tb/tb_register_hazard_scoreboard.sv
// Directed self-checking bench for the hazard scoreboard.
// Inputs change 1 time unit after posedge; outputs sampled before next edge.
module tb_register_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        use_rs1;
    logic        use_rs2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        stall;
    logic        issue_fire;
    logic [31:0] pending_mask;
    logic        err_underflow;

    int vecs;
    int errs;

    register_hazard_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .use_rs1       (use_rs1),
        .use_rs2       (use_rs2),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .stall         (stall),
        .issue_fire    (issue_fire),
        .pending_mask  (pending_mask),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        issue_rs1   = 5'd0;
        issue_rs2   = 5'd0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        wb_valid    = 1'b0;
        wb_rd       = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        idle();
        issue_valid = 1'b1;
        issue_rd    = rd;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        vecs++;
        if (pending_mask !== 32'h0) begin
            errs++;
            $display("FAIL reset_mask got=%h exp=%h",
                     pending_mask, 32'h0);
        end
        vecs++;
        if (err_underflow !== 1'b0) begin
            errs++;
            $display("FAIL reset_err got=%b exp=0",
                     err_underflow);
        end
        vecs++;
        if (stall !== 1'b0 || issue_fire !== 1'b0) begin
            errs++;
            $display("FAIL reset_idle stall=%b fire=%b exp=0/0",
                     stall, issue_fire);
        end
    endtask

    task automatic test_issue_rd();
        issue(5'd5);
        settle();
        vecs++;
        if (stall !== 1'b0 || issue_fire !== 1'b1) begin
            errs++;
            $display("FAIL issue5 stall=%b fire=%b exp=0/1",
                     stall, issue_fire);
        end
        tick();
        idle();
        settle();
        vecs++;
        if (pending_mask !== 32'h20) begin
            errs++;
            $display("FAIL issue5_mask got=%h exp=%h",
                     pending_mask, 32'h20);
        end
    endtask

    task automatic test_raw_bypass();
        idle();
        issue_valid = 1'b1;
        issue_rs1   = 5'd5;
        use_rs1     = 1'b1;
        settle();
        vecs++;
        if (stall !== 1'b1 || issue_fire !== 1'b0) begin
            errs++;
            $display("FAIL raw5 stall=%b fire=%b exp=1/0",
                     stall, issue_fire);
        end
        tick();
        vecs++;
        if (stall !== 1'b1) begin
            errs++;
            $display("FAIL raw5_hold stall=%b exp=1", stall);
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        settle();
        vecs++;
        if (stall !== 1'b0 || issue_fire !== 1'b1) begin
            errs++;
            $display("FAIL raw5_wb stall=%b fire=%b exp=0/1",
                     stall, issue_fire);
        end
        tick();
        idle();
        settle();
        vecs++;
        if (pending_mask !== 32'h0 || err_underflow !== 1'b0) begin
            errs++;
            $display("FAIL raw5_after mask=%h err=%b exp=0/0",
                     pending_mask, err_underflow);
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 3; k++) begin
            issue(5'd7);
            settle();
            vecs++;
            if (stall !== 1'b0) begin
                errs++;
                $display("FAIL sat_fill%0d stall=%b exp=0",
                         k, stall);
            end
            tick();
        end
        issue(5'd7);
        settle();
        vecs++;
        if (stall !== 1'b1 || pending_mask !== 32'h80) begin
            errs++;
            $display("FAIL sat_full stall=%b mask=%h exp=1/80",
                     stall, pending_mask);
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        settle();
        vecs++;
        if (stall !== 1'b0 || issue_fire !== 1'b1) begin
            errs++;
            $display("FAIL sat_wb stall=%b fire=%b exp=0/1",
                     stall, issue_fire);
        end
        tick();
        issue(5'd7);
        settle();
        vecs++;
        if (stall !== 1'b1) begin
            errs++;
            $display("FAIL sat_still3 stall=%b exp=1", stall);
        end
        idle();
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        tick();
        tick();
        settle();
        vecs++;
        if (pending_mask !== 32'h80) begin
            errs++;
            $display("FAIL sat_drain2 mask=%h exp=80",
                     pending_mask);
        end
        tick();
        idle();
        settle();
        vecs++;
        if (pending_mask !== 32'h0 || err_underflow !== 1'b0) begin
            errs++;
            $display("FAIL sat_drain3 mask=%h err=%b exp=0/0",
                     pending_mask, err_underflow);
        end
    endtask

    task automatic test_x0();
        idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        issue_rs1   = 5'd0;
        use_rs1     = 1'b1;
        wb_valid    = 1'b1;
        wb_rd       = 5'd0;
        settle();
        vecs++;
        if (stall !== 1'b0 || issue_fire !== 1'b1) begin
            errs++;
            $display("FAIL x0_stall stall=%b fire=%b exp=0/1",
                     stall, issue_fire);
        end
        tick();
        idle();
        settle();
        vecs++;
        if (pending_mask !== 32'h0 || err_underflow !== 1'b0) begin
            errs++;
            $display("FAIL x0_state mask=%h err=%b exp=0/0",
                     pending_mask, err_underflow);
        end
    endtask

    task automatic test_underflow();
        idle();
        wb_valid = 1'b1;
        wb_rd    = 5'd9;
        tick();
        idle();
        settle();
        vecs++;
        if (err_underflow !== 1'b1 || pending_mask !== 32'h0) begin
            errs++;
            $display("FAIL uf_set err=%b mask=%h exp=1/0",
                     err_underflow, pending_mask);
        end
        tick();
        tick();
        vecs++;
        if (err_underflow !== 1'b1) begin
            errs++;
            $display("FAIL uf_sticky err=%b exp=1",
                     err_underflow);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        vecs++;
        if (err_underflow !== 1'b0) begin
            errs++;
            $display("FAIL uf_clear err=%b exp=0",
                     err_underflow);
        end
    endtask

    task automatic test_reset_mid();
        issue(5'd3);
        tick();
        tick();
        idle();
        issue_valid = 1'b1;
        issue_rs2   = 5'd3;
        use_rs2     = 1'b1;
        settle();
        vecs++;
        if (stall !== 1'b1 || pending_mask !== 32'h8) begin
            errs++;
            $display("FAIL rs2_busy stall=%b mask=%h exp=1/8",
                     stall, pending_mask);
        end
        use_rs2 = 1'b0;
        settle();
        vecs++;
        if (stall !== 1'b0) begin
            errs++;
            $display("FAIL rs2_unused stall=%b exp=0", stall);
        end
        idle();
        rst         = 1'b1;
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
        tick();
        rst = 1'b0;
        idle();
        settle();
        vecs++;
        if (pending_mask !== 32'h0) begin
            errs++;
            $display("FAIL rstmid_mask got=%h exp=0",
                     pending_mask);
        end
        issue_valid = 1'b1;
        issue_rs2   = 5'd3;
        use_rs2     = 1'b1;
        settle();
        vecs++;
        if (stall !== 1'b0 || issue_fire !== 1'b1) begin
            errs++;
            $display("FAIL rstmid_rs2 stall=%b fire=%b exp=0/1",
                     stall, issue_fire);
        end
        tick();
        idle();
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst  = 1'b1;
        idle();
        test_reset();
        test_issue_rd();
        test_raw_bypass();
        test_saturate();
        test_x0();
        test_underflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
